// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the mm:ss stopwatch engine.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t ONES_MAX = 4'd9;
  localparam bcd_digit_t TENS_MAX = 4'd5;

endpackage

// File: rtl/stopwatch_key_debounce.sv
// One raw active-low pushbutton: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on each debounced press (1->0 of the level).
module key_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic press_o
);
  import stopwatch_pkg::*;

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Edge detect runs one stage behind the level so the pulse is fully registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q       <= 2'b11;
      level_q      <= 1'b1;
      level_prev_q <= 1'b1;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], key_i};
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
      press_q      <= level_prev_q & ~level_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_bcd_core.sv
// mm:ss stopwatch: debounced start/clear keys, IDLE/RUN/PAUSE control,
// clock-enable prescaler, cascaded BCD digits and a tick-driven LED toggle.
module stopwatch_bcd_core #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_start,
  input  logic        key_clear,
  output logic [15:0] bcd,
  output logic        running,
  output logic        tick,
  output logic        led
);
  import stopwatch_pkg::*;

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

  logic [1:0]    key_raw;
  logic [1:0]    press;
  logic          start_p, clear_p;
  state_t        state_q;
  logic          running_q, tick_q, led_q;
  logic [PW-1:0] presc_q;
  logic [15:0]   bcd_q, bcd_d;

  assign key_raw = {key_clear, key_start};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key (
        .clk     (clk),
        .rst     (rst),
        .key_i   (key_raw[gi]),
        .press_o (press[gi])
      );
    end
  endgenerate

  assign start_p = press[0];
  assign clear_p = press[1];

  // Incremented time value; only loaded on a prescaler wrap.
  always_comb begin
    bcd_digit_t d0, d1, d2, d3;
    d0 = bcd_q[3:0];
    d1 = bcd_q[7:4];
    d2 = bcd_q[11:8];
    d3 = bcd_q[15:12];
    if (d0 != ONES_MAX) begin
      d0 = d0 + 4'd1;
    end else begin
      d0 = '0;
      if (d1 != TENS_MAX) begin
        d1 = d1 + 4'd1;
      end else begin
        d1 = '0;
        if (d2 != ONES_MAX) begin
          d2 = d2 + 4'd1;
        end else begin
          d2 = '0;
          d3 = (d3 != TENS_MAX) ? d3 + 4'd1 : '0;
        end
      end
    end
    bcd_d = {d3, d2, d1, d0};
  end

  // Clear outranks both a same-cycle start press and a same-cycle tick.
  always_ff @(posedge clk) begin
    if (!rst || clear_p) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      led_q     <= 1'b0;
      bcd_q     <= '0;
    end else begin
      tick_q <= 1'b0;
      if (state_q == RUN) begin
        if (presc_q == PW'(DIV - 1)) begin
          presc_q <= '0;
          tick_q  <= 1'b1;
          led_q   <= ~led_q;
          bcd_q   <= bcd_d;
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
      if (start_p) begin
        case (state_q)
          IDLE, PAUSE: begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
          RUN: begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end
          default: begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bcd     = bcd_q;
  assign running = running_q;
  assign tick    = tick_q;
  assign led     = led_q;

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Stopwatch bench: directed steps plus random key activity, every cycle
// compared against an elapsed-time reference model.
module tb_stopwatch_bcd_core;
  localparam int DIV = 10;
  localparam int DB  = 4;
  localparam int LAT = DB + 4;  // edges from first low sample to visible state change
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_start = 1'b1;
  logic key_clear = 1'b1;
  logic [15:0] bcd;
  logic running, tick, led;

  int checks = 0, failures = 0;
  int edge_n = 0, last_rise = -1, last_tick = -1, t0 = 0;
  bit prev_run = 1'b0;
  logic [15:0] bcd_at_pause;

  int m_state = M_IDLE, m_phase = 0, m_secs = 0;
  bit m_led = 1'b0, m_tick = 1'b0;
  int start_q[$];
  int clear_q[$];

  always #5 clk = ~clk;

  stopwatch_bcd_core #(.CLK_HZ(10), .TICK_HZ(1), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_start (key_start),
    .key_clear (key_clear),
    .bcd       (bcd),
    .running   (running),
    .tick      (tick),
    .led       (led)
  );

  function automatic logic [15:0] to_bcd(int t);
    int mm, ss;
    mm = t / 60;
    ss = t % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: elapsed seconds and RUN cycles since the last tick.
  function automatic void model_edge();
    bit s_evt, c_evt;
    s_evt = 1'b0;
    c_evt = 1'b0;
    if (start_q.size() > 0 && start_q[0] == edge_n) begin
      s_evt = 1'b1;
      void'(start_q.pop_front());
    end
    if (clear_q.size() > 0 && clear_q[0] == edge_n) begin
      c_evt = 1'b1;
      void'(clear_q.pop_front());
    end
    if (!rst || c_evt) begin
      m_state = M_IDLE; m_phase = 0; m_secs = 0; m_led = 1'b0; m_tick = 1'b0;
      if (!rst) begin
        start_q.delete();
        clear_q.delete();
      end
    end else begin
      m_tick = 1'b0;
      if (m_state == M_RUN) begin
        m_phase++;
        if (m_phase == DIV) begin
          m_phase = 0;
          m_tick  = 1'b1;
          m_led   = !m_led;
          m_secs  = (m_secs + 1) % 3600;
        end
      end
      if (s_evt) m_state = (m_state == M_RUN) ? M_PAUSE : M_RUN;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    if (running && !prev_run) last_rise = edge_n;
    prev_run = running;
    if (tick) last_tick = edge_n;
    chk($sformatf("cycle%0d", edge_n), {13'b0, bcd, running, tick, led},
        {13'b0, to_bcd(m_secs), m_state == M_RUN, m_tick, m_led});
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic key_down(bit s, bit c, int hold);
    if (s) begin
      key_start = 1'b0;
      if (hold >= DB) start_q.push_back(edge_n + LAT);
    end
    if (c) begin
      key_clear = 1'b0;
      if (hold >= DB) clear_q.push_back(edge_n + LAT);
    end
    repeat (hold) step();
    key_start = 1'b1;
    key_clear = 1'b1;
  endtask

  task automatic press(bit s, bit c, int hold);
    key_down(s, c, hold);
    idle(DB + 6);
  endtask

  task automatic wait_tick(int max);
    int n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < max);
    chk("tick_seen", {31'b0, tick}, 32'd1);
  endtask

  task automatic run_to(logic [15:0] v, int max);
    int n = 0;
    while (bcd !== v && n < max) begin
      step();
      n++;
    end
    chk("reach", {16'b0, bcd}, {16'b0, v});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    rst = 1'b0;
    idle(2);
    chk("rst_bcd", {16'b0, bcd}, 32'h0);
    chk("rst_flags", {29'b0, running, tick, led}, 32'h0);
    rst = 1'b1;
    idle(3);

    // Reset mid-run at 00:07
    press(1'b1, 1'b0, 12);
    run_to(16'h0007, 200);
    rst = 1'b0;
    step();
    chk("midrun_rst", {13'b0, bcd, running, tick, led}, 32'h0);
    rst = 1'b1;
    idle(DB + 6);

    // Start latency, first tick, 100 RUN cycles
    t0 = edge_n;
    key_down(1'b1, 1'b0, 12);
    chk("start_lat", 32'(last_rise - t0), 32'(LAT));
    wait_tick(3 * DIV);
    chk("first_tick_gap", 32'(last_tick - last_rise), 32'(DIV));
    chk("first_tick_bcd", {16'b0, bcd}, 32'h0001);
    chk("first_tick_led", {31'b0, led}, 32'h1);
    while (edge_n < last_rise + 100) step();
    chk("run100_bcd", {16'b0, bcd}, 32'h0010);

    // Bounce: short lows never register
    repeat (5) begin
      key_start = 1'b0;
      idle(3);
      key_start = 1'b1;
      idle(1);
    end
    idle(DB + 6);
    chk("bounce_running", {31'b0, running}, 32'h1);
    press(1'b1, 1'b0, 6);
    chk("bounce_then_pause", {31'b0, running}, 32'h0);

    // Pause after 4 RUN cycles past a tick, then resume
    press(1'b1, 1'b0, 6);
    wait_tick(3 * DIV);
    idle(DIV - 4);
    press(1'b1, 1'b0, 6);
    chk("paused", {31'b0, running}, 32'h0);
    bcd_at_pause = bcd;
    idle(20);
    chk("pause_frozen", {16'b0, bcd}, {16'b0, bcd_at_pause});
    key_down(1'b1, 1'b0, 6);
    wait_tick(3 * DIV);
    chk("resume_gap", 32'(last_tick - last_rise), 32'(DIV - 4));

    // Carries and wrap
    press(1'b0, 1'b1, 6);
    chk("cleared", {16'b0, bcd}, 32'h0);
    press(1'b1, 1'b0, 6);
    run_to(16'h0009, 200);
    wait_tick(3 * DIV);
    chk("carry_sec", {16'b0, bcd}, 32'h0010);
    run_to(16'h0059, 1000);
    wait_tick(3 * DIV);
    chk("carry_min", {16'b0, bcd}, 32'h0100);
    run_to(16'h5959, 40000);
    wait_tick(3 * DIV);
    chk("wrap_bcd", {16'b0, bcd}, 32'h0000);
    chk("wrap_running", {31'b0, running}, 32'h1);

    // Clear and start on the same edge: clear wins
    wait_tick(3 * DIV);
    if (!led) wait_tick(3 * DIV);
    key_down(1'b1, 1'b1, 6);
    idle(DB + 6);
    chk("prio", {13'b0, bcd, running, tick, led}, 32'h0);

    // Random key activity, checked cycle by cycle against the model
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: press(1'b1, 1'b0, $urandom_range(DB, DB + 5));
        4: press(1'b0, 1'b1, $urandom_range(DB, DB + 5));
        5, 6: begin
          if ($urandom_range(0, 1) == 0) key_start = 1'b0;
          else key_clear = 1'b0;
          idle($urandom_range(1, DB - 1));
          key_start = 1'b1;
          key_clear = 1'b1;
          idle(DB + 3);
        end
        7: idle($urandom_range(1, 3 * DIV));
        8: begin
          key_start = 1'b0;
          idle($urandom_range(1, DB + 2));
          rst = 1'b0;
          key_start = 1'b1;
          step();
          rst = 1'b1;
          idle(DB + 6);
        end
        default: idle($urandom_range(DIV, 5 * DIV));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
